// File: rtl/mem_burst_driver.sv
// Command-driven burst traffic generator for a single-port memory.
// Issues gap-free write/read beats from a data pattern and optionally verifies read-back data.
module mem_burst_driver #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned LEN_WIDTH  = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned ERR_WIDTH  = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic [1:0]            i_cmd_op,
  input  logic [1:0]            i_cmd_mode,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [LEN_WIDTH-1:0]  i_cmd_len,
  input  logic [DATA_WIDTH-1:0] i_cmd_seed,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_wr_en,
  output logic                  o_rd_en,
  output logic [ADDR_WIDTH-1:0] o_address,
  output logic [DATA_WIDTH-1:0] o_wr_data,
  input  logic [DATA_WIDTH-1:0] i_rd_data,
  output logic                  o_rd_valid,
  output logic [DATA_WIDTH-1:0] o_rd_data,
  output logic                  o_err,
  output logic [ERR_WIDTH-1:0]  o_err_count,
  output logic [ADDR_WIDTH-1:0] o_first_err_addr
);

  localparam int unsigned DRAIN_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  localparam logic [1:0] OP_WRITE   = 2'b00;
  localparam logic [1:0] OP_VERIFY  = 2'b10;
  localparam logic [1:0] MODE_CONST = 2'b01;
  localparam logic [1:0] MODE_XOR   = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_TURN, S_READ, S_DRAIN, S_DONE
  } state_t;

  state_t                state, state_d;
  logic [1:0]            op_q, op_d, mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d, idx_q, idx_d;
  logic [DATA_WIDTH-1:0] seed_q, seed_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;

  logic                  busy_d, done_d, wr_en_d, rd_en_d;
  logic [ADDR_WIDTH-1:0] address_d;
  logic [DATA_WIDTH-1:0] wr_data_d;
  logic                  err_d;
  logic [ERR_WIDTH-1:0]  err_count_d;
  logic [ADDR_WIDTH-1:0] first_err_addr_d;

  // Read pipeline: valid, expected data and address travel with each read beat.
  logic                  pipe_v    [RD_LATENCY];
  logic [DATA_WIDTH-1:0] pipe_exp  [RD_LATENCY];
  logic [ADDR_WIDTH-1:0] pipe_addr [RD_LATENCY];

  logic                  accept, last_beat, cap, mismatch, is_verify;
  logic [LEN_WIDTH-1:0]  next_idx;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [DATA_WIDTH-1:0] cur_exp;

  function automatic logic [DATA_WIDTH-1:0] pattern(
    input logic [1:0]            mode,
    input logic [DATA_WIDTH-1:0] seed,
    input logic [LEN_WIDTH-1:0]  idx,
    input logic [ADDR_WIDTH-1:0] addr
  );
    case (mode)
      MODE_CONST: pattern = seed;
      MODE_XOR:   pattern = seed ^ DATA_WIDTH'(addr);
      default:    pattern = seed + DATA_WIDTH'(idx);
    endcase
  endfunction

  assign o_cmd_ready = (state == S_IDLE) && !i_rst;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign is_verify   = (op_q == OP_VERIFY);
  assign last_beat   = (idx_q == LEN_WIDTH'(len_q - LEN_WIDTH'(1)));
  assign next_idx    = LEN_WIDTH'(idx_q + LEN_WIDTH'(1));
  assign next_addr   = ADDR_WIDTH'(addr_q + ADDR_WIDTH'(next_idx));
  assign cur_exp     = pattern(mode_q, seed_q, idx_q, o_address);
  assign cap         = pipe_v[RD_LATENCY-1];
  assign mismatch    = cap && is_verify && (i_rd_data != pipe_exp[RD_LATENCY-1]);

  // Next-state and next-output logic.
  always_comb begin
    state_d          = state;
    op_d             = op_q;
    mode_d           = mode_q;
    addr_d           = addr_q;
    len_d            = len_q;
    seed_d           = seed_q;
    idx_d            = idx_q;
    drain_d          = drain_q;
    busy_d           = o_busy;
    done_d           = 1'b0;
    wr_en_d          = 1'b0;
    rd_en_d          = 1'b0;
    address_d        = o_address;
    wr_data_d        = o_wr_data;
    err_d            = o_err;
    err_count_d      = o_err_count;
    first_err_addr_d = o_first_err_addr;

    unique case (state)
      S_IDLE: begin
        if (accept) begin
          op_d   = i_cmd_op;
          mode_d = i_cmd_mode;
          addr_d = i_cmd_addr;
          len_d  = i_cmd_len;
          seed_d = i_cmd_seed;
          idx_d  = '0;
          busy_d = 1'b1;
          if (i_cmd_len == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else if (i_cmd_op == OP_WRITE || i_cmd_op == OP_VERIFY) begin
            state_d   = S_WRITE;
            wr_en_d   = 1'b1;
            address_d = i_cmd_addr;
            wr_data_d = pattern(i_cmd_mode, i_cmd_seed, '0, i_cmd_addr);
          end else begin
            state_d   = S_READ;
            rd_en_d   = 1'b1;
            address_d = i_cmd_addr;
          end
        end
      end
      S_WRITE: begin
        if (last_beat) begin
          if (is_verify) begin
            state_d = S_TURN;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          wr_en_d   = 1'b1;
          idx_d     = next_idx;
          address_d = next_addr;
          wr_data_d = pattern(mode_q, seed_q, next_idx, next_addr);
        end
      end
      S_TURN: begin
        state_d   = S_READ;
        rd_en_d   = 1'b1;
        idx_d     = '0;
        address_d = addr_q;
      end
      S_READ: begin
        if (last_beat) begin
          state_d = S_DRAIN;
          drain_d = DRAIN_W'(RD_LATENCY - 1);
        end else begin
          rd_en_d   = 1'b1;
          idx_d     = next_idx;
          address_d = next_addr;
        end
      end
      S_DRAIN: begin
        // Leaves when the last beat is being captured, so DONE lines up with its valid.
        if (drain_q == '0) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          drain_d = DRAIN_W'(drain_q - DRAIN_W'(1));
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (accept) begin
      err_d            = 1'b0;
      err_count_d      = '0;
      first_err_addr_d = '0;
    end else if (mismatch) begin
      err_d = 1'b1;
      if (o_err_count != '1) err_count_d = ERR_WIDTH'(o_err_count + ERR_WIDTH'(1));
      if (!o_err) first_err_addr_d = pipe_addr[RD_LATENCY-1];
    end
  end

  // State, command and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= S_IDLE;
      op_q             <= '0;
      mode_q           <= '0;
      addr_q           <= '0;
      len_q            <= '0;
      seed_q           <= '0;
      idx_q            <= '0;
      drain_q          <= '0;
      o_busy           <= 1'b0;
      o_done           <= 1'b0;
      o_wr_en          <= 1'b0;
      o_rd_en          <= 1'b0;
      o_address        <= '0;
      o_wr_data        <= '0;
      o_err            <= 1'b0;
      o_err_count      <= '0;
      o_first_err_addr <= '0;
    end else begin
      state            <= state_d;
      op_q             <= op_d;
      mode_q           <= mode_d;
      addr_q           <= addr_d;
      len_q            <= len_d;
      seed_q           <= seed_d;
      idx_q            <= idx_d;
      drain_q          <= drain_d;
      o_busy           <= busy_d;
      o_done           <= done_d;
      o_wr_en          <= wr_en_d;
      o_rd_en          <= rd_en_d;
      o_address        <= address_d;
      o_wr_data        <= wr_data_d;
      o_err            <= err_d;
      o_err_count      <= err_count_d;
      o_first_err_addr <= first_err_addr_d;
    end
  end

  // Read pipeline and capture of returned data.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int k = 0; k < int'(RD_LATENCY); k++) begin
        pipe_v[k]    <= 1'b0;
        pipe_exp[k]  <= '0;
        pipe_addr[k] <= '0;
      end
      o_rd_valid <= 1'b0;
      o_rd_data  <= '0;
    end else begin
      pipe_v[0]    <= o_rd_en;
      pipe_exp[0]  <= cur_exp;
      pipe_addr[0] <= o_address;
      for (int k = 1; k < int'(RD_LATENCY); k++) begin
        pipe_v[k]    <= pipe_v[k-1];
        pipe_exp[k]  <= pipe_exp[k-1];
        pipe_addr[k] <= pipe_addr[k-1];
      end
      o_rd_valid <= cap;
      if (cap) o_rd_data <= i_rd_data;
    end
  end

endmodule

// File: tb/tb_mem_burst_driver.sv
// Bench for mem_burst_driver: two instances (read latency 1 and 3), each with its own memory model,
// driven by directed and random commands and checked cycle by cycle against a command-level model.
module tb_mem_burst_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]        rst, cmd_valid, cmd_ready, busy, done, wr_en, rd_en, rd_valid, err;
  logic [1:0][1:0]   cmd_op, cmd_mode;
  logic [1:0][7:0]   cmd_addr, cmd_len, cmd_seed, address, wr_data, rd_in, rd_data, first_err_addr;
  logic [1:0][15:0]  err_count;

  logic [1:0]        cflip;
  logic [1:0][7:0]   caddr;

  logic [7:0] mem0 [256];
  logic [7:0] mem1 [256];
  logic [7:0] rp0;
  logic [7:0] rp1 [3];

  logic [7:0] gold  [2][256];
  bit         known [2][256];

  int checks = 0;
  int failures = 0;

  mem_burst_driver #(.RD_LATENCY(1)) dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_cmd_valid(cmd_valid[0]), .o_cmd_ready(cmd_ready[0]),
    .i_cmd_op(cmd_op[0]), .i_cmd_mode(cmd_mode[0]), .i_cmd_addr(cmd_addr[0]),
    .i_cmd_len(cmd_len[0]), .i_cmd_seed(cmd_seed[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_wr_en(wr_en[0]), .o_rd_en(rd_en[0]), .o_address(address[0]), .o_wr_data(wr_data[0]),
    .i_rd_data(rd_in[0]), .o_rd_valid(rd_valid[0]), .o_rd_data(rd_data[0]), .o_err(err[0]),
    .o_err_count(err_count[0]), .o_first_err_addr(first_err_addr[0])
  );

  mem_burst_driver #(.RD_LATENCY(3)) dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_cmd_valid(cmd_valid[1]), .o_cmd_ready(cmd_ready[1]),
    .i_cmd_op(cmd_op[1]), .i_cmd_mode(cmd_mode[1]), .i_cmd_addr(cmd_addr[1]),
    .i_cmd_len(cmd_len[1]), .i_cmd_seed(cmd_seed[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_wr_en(wr_en[1]), .o_rd_en(rd_en[1]), .o_address(address[1]), .o_wr_data(wr_data[1]),
    .i_rd_data(rd_in[1]), .o_rd_valid(rd_valid[1]), .o_rd_data(rd_data[1]), .o_err(err[1]),
    .o_err_count(err_count[1]), .o_first_err_addr(first_err_addr[1])
  );

  // Synchronous memories; cflip/caddr inject a bit-0 error on reads of one address.
  always @(posedge clk) begin
    if (wr_en[0]) mem0[address[0]] <= wr_data[0];
    if (wr_en[1]) mem1[address[1]] <= wr_data[1];
    rp0    <= mem0[address[0]] ^ {7'd0, cflip[0] && (address[0] == caddr[0])};
    rp1[0] <= mem1[address[1]] ^ {7'd0, cflip[1] && (address[1] == caddr[1])};
    rp1[1] <= rp1[0];
    rp1[2] <= rp1[1];
  end
  assign rd_in[0] = rp0;
  assign rd_in[1] = rp1[2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int mode, input int seed, input int i, input int a);
    case (mode)
      1:       pat = 8'(seed);
      2:       pat = 8'(seed ^ a);
      default: pat = 8'(seed + i);
    endcase
  endfunction

  // One command, checked every cycle from acceptance until the cycle after completion.
  task automatic run_cmd(input int u, input int op, input int mode, input int addr, input int len,
                         input int seed, input bit hold, input bit cf, input int ca);
    int  lat, rs, dc, ecnt, efirst, i, a, t;
    bit  wph, rph, ver, ew, er, ev, bad;
    logic [7:0] exp_rd;
    lat = (u == 0) ? 1 : 3;
    wph = (op == 0) || (op == 2);
    rph = (op != 0);
    ver = (op == 2);
    rs  = wph ? len + 2 : 1;
    if (len == 0)      dc = 1;
    else if (!rph)     dc = len + 1;
    else               dc = rs + len + lat;
    ecnt = 0;
    efirst = 0;
    cflip[u] = cf;
    caddr[u] = 8'(ca);

    @(negedge clk);
    t = 0;
    while (!cmd_ready[u] && t < 50) begin
      @(negedge clk);
      t++;
    end
    check($sformatf("u%0d ready", u), 32'(cmd_ready[u]), 32'd1);
    cmd_valid[u] = 1'b1;
    cmd_op[u]    = 2'(op);
    cmd_mode[u]  = 2'(mode);
    cmd_addr[u]  = 8'(addr);
    cmd_len[u]   = 8'(len);
    cmd_seed[u]  = 8'(seed);
    @(posedge clk);

    for (int c = 1; c <= dc + 1; c++) begin
      @(negedge clk);
      if ((!hold && c == 1) || (hold && c == dc)) cmd_valid[u] = 1'b0;
      if (hold) cmd_addr[u] = 8'($urandom_range(0, 255));

      ew = wph && (len > 0) && (c <= len);
      check($sformatf("u%0d c%0d wr_en", u, c), 32'(wr_en[u]), 32'(ew));
      if (ew) begin
        i = c - 1;
        a = (addr + i) & 255;
        check($sformatf("u%0d c%0d wr_addr", u, c), 32'(address[u]), 32'(a));
        check($sformatf("u%0d c%0d wr_data", u, c), 32'(wr_data[u]), 32'(pat(mode, seed, i, a)));
        gold[u][a]  = pat(mode, seed, i, a);
        known[u][a] = 1'b1;
      end else if (wph && len > 0) begin
        check($sformatf("u%0d c%0d wr_data_hold", u, c), 32'(wr_data[u]),
              32'(pat(mode, seed, len - 1, (addr + len - 1) & 255)));
      end

      er = rph && (len > 0) && (c >= rs) && (c < rs + len);
      check($sformatf("u%0d c%0d rd_en", u, c), 32'(rd_en[u]), 32'(er));
      if (er) check($sformatf("u%0d c%0d rd_addr", u, c), 32'(address[u]), 32'((addr + c - rs) & 255));

      i  = c - rs - lat - 1;
      ev = rph && (len > 0) && (i >= 0) && (i < len);
      check($sformatf("u%0d c%0d rd_valid", u, c), 32'(rd_valid[u]), 32'(ev));
      if (ev) begin
        a   = (addr + i) & 255;
        bad = cf && (a == ca);
        exp_rd = gold[u][a] ^ {7'd0, bad};
        if (known[u][a]) check($sformatf("u%0d c%0d rd_data", u, c), 32'(rd_data[u]), 32'(exp_rd));
        if (ver && bad) begin
          if (ecnt == 0) efirst = a;
          ecnt++;
        end
      end
      check($sformatf("u%0d c%0d err", u, c), 32'(err[u]), 32'(ecnt > 0));
      check($sformatf("u%0d c%0d err_count", u, c), 32'(err_count[u]), 32'(ecnt));
      check($sformatf("u%0d c%0d first_err_addr", u, c), 32'(first_err_addr[u]), 32'(efirst));
      check($sformatf("u%0d c%0d done", u, c), 32'(done[u]), 32'(c == dc));
      check($sformatf("u%0d c%0d busy", u, c), 32'(busy[u]), 32'(c <= dc));
    end
    cflip[u] = 1'b0;
  endtask

  // Reset in the middle of an 8-beat write on instance 0.
  task automatic reset_mid_burst();
    logic [7:0] e;
    run_cmd(0, 0, 1, 8'h40, 8, 8'h33, 1'b0, 1'b0, 0);
    @(negedge clk);
    check("rst ready", 32'(cmd_ready[0]), 32'd1);
    cmd_valid[0] = 1'b1; cmd_op[0] = 2'd0; cmd_mode[0] = 2'd0;
    cmd_addr[0] = 8'h40; cmd_len[0] = 8'd8; cmd_seed[0] = 8'h80;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      check($sformatf("rst c%0d wr_en", c), 32'(wr_en[0]), 32'd1);
      check($sformatf("rst c%0d wr_data", c), 32'(wr_data[0]), 32'(8'h80 + 8'(c - 1)));
    end
    rst[0] = 1'b1;
    @(negedge clk);
    check("rst wr_en after", 32'(wr_en[0]), 32'd0);
    check("rst busy after", 32'(busy[0]), 32'd0);
    check("rst done after", 32'(done[0]), 32'd0);
    check("rst ready during", 32'(cmd_ready[0]), 32'd0);
    rst[0] = 1'b0;
    @(negedge clk);
    check("rst ready after", 32'(cmd_ready[0]), 32'd1);
    check("rst done later", 32'(done[0]), 32'd0);
    check("rst wr_en later", 32'(wr_en[0]), 32'd0);
    for (int k = 0; k < 8; k++) begin
      e = (k < 3) ? 8'(8'h80 + k) : 8'h33;
      check($sformatf("rst mem %0d", k), 32'(mem0[8'h40 + k]), 32'(e));
      gold[0][8'h40 + k] = e;
    end
  endtask

  initial begin
    int op, mode, addr, len, seed, u, ca;
    bit hold, cf;
    rst = 2'b11; cmd_valid = '0; cmd_op = '0; cmd_mode = '0;
    cmd_addr = '0; cmd_len = '0; cmd_seed = '0; cflip = '0; caddr = '0;
    for (int k = 0; k < 256; k++) begin
      known[0][k] = 1'b0; known[1][k] = 1'b0;
      gold[0][k] = '0;    gold[1][k] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      check($sformatf("reset u%0d ready", k), 32'(cmd_ready[k]), 32'd0);
      check($sformatf("reset u%0d outs", k),
            32'({busy[k], done[k], wr_en[k], rd_en[k], rd_valid[k], err[k]}), 32'd0);
      check($sformatf("reset u%0d err_count", k), 32'(err_count[k]), 32'd0);
      check($sformatf("reset u%0d address", k), 32'(address[k]), 32'd0);
    end
    rst = 2'b00;

    run_cmd(0, 0, 0, 8'h10, 4, 8'hA0, 1'b0, 1'b0, 0);
    run_cmd(0, 1, 0, 8'h10, 4, 8'hA0, 1'b0, 1'b0, 0);
    run_cmd(0, 0, 1, 8'hFE, 4, 8'h5A, 1'b0, 1'b0, 0);
    run_cmd(0, 1, 0, 8'hFE, 4, 8'h00, 1'b0, 1'b0, 0);
    run_cmd(0, 2, 2, 8'h20, 4, 8'hFF, 1'b0, 1'b0, 0);
    run_cmd(0, 2, 2, 8'h20, 4, 8'hFF, 1'b0, 1'b1, 8'h22);
    run_cmd(0, 0, 0, 8'h00, 0, 8'h11, 1'b0, 1'b0, 0);
    run_cmd(0, 0, 0, 8'h30, 6, 8'h01, 1'b1, 1'b0, 0);
    run_cmd(1, 0, 0, 8'h50, 3, 8'hC0, 1'b0, 1'b0, 0);
    run_cmd(1, 1, 0, 8'h50, 3, 8'h00, 1'b0, 1'b0, 0);
    run_cmd(1, 2, 2, 8'h60, 5, 8'h3C, 1'b1, 1'b1, 8'h63);
    reset_mid_burst();

    for (int n = 0; n < 80; n++) begin
      u    = n % 2;
      op   = int'($urandom_range(0, 3));
      mode = int'($urandom_range(0, 3));
      addr = int'($urandom_range(0, 255));
      len  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 12));
      seed = int'($urandom_range(0, 255));
      hold = ($urandom_range(0, 3) == 0);
      cf   = (len > 0) && ($urandom_range(0, 1) == 1);
      ca   = (len > 0) ? ((addr + int'($urandom_range(0, len - 1))) & 255) : 0;
      run_cmd(u, op, mode, addr, len, seed, hold, cf, ca);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_burst_driver.md
Name: mem_burst_driver

Overview:
Synthesizable, command-driven burst traffic generator for the single-port memory.
- Accepts one burst command at a time and drives the memory's write/read port with consecutive single-cycle beats.
- Generates write data from a selectable pattern and streams captured read data.
- Verify mode writes a burst, reads it back and compares every beat against the expected pattern, counting mismatches.
- Sits between a test sequencer/CPU-side controller and the memory, replacing task-based stimulus in system-level benches and BIST.

Parameters:
DATA_WIDTH, 8, memory data width in bits
ADDR_WIDTH, 8, memory address width in bits
LEN_WIDTH, 8, width of burst length field (max burst 2^LEN_WIDTH-1 beats)
RD_LATENCY, 1, cycles from a cycle with o_rd_en=1 until i_rd_data is valid (>=1)
ERR_WIDTH, 16, width of mismatch counter

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_cmd_valid  in  1  command present
o_cmd_ready  out  1  driver can accept command
i_cmd_op  in  2  00 WRITE, 01 READ, 10 VERIFY (write then read-compare), 11 treated as READ
i_cmd_mode  in  2  data pattern: 00 INCR, 01 CONST, 10 ADDR_XOR, 11 treated as INCR
i_cmd_addr  in  ADDR_WIDTH  start address
i_cmd_len  in  LEN_WIDTH  number of beats
i_cmd_seed  in  DATA_WIDTH  pattern seed
o_busy  out  1  command in progress
o_done  out  1  one-cycle pulse at command completion
o_wr_en  out  1  memory write enable
o_rd_en  out  1  memory read enable
o_address  out  ADDR_WIDTH  memory address
o_wr_data  out  DATA_WIDTH  memory write data
i_rd_data  in  DATA_WIDTH  memory read data
o_rd_valid  out  1  captured read beat valid
o_rd_data  out  DATA_WIDTH  captured read beat
o_err  out  1  sticky: any mismatch in current/last VERIFY
o_err_count  out  ERR_WIDTH  mismatches, saturating at all-ones
o_first_err_addr  out  ADDR_WIDTH  address of first mismatch

Behaviour:
- Reset (i_rst=1 at an edge): state IDLE; all outputs 0; read pipeline flushed.
  - o_cmd_ready is forced 0 while i_rst=1.
  - Reset mid-burst aborts at that edge: enables low from the next cycle, no o_done.
- o_cmd_ready = (state==IDLE) && !i_rst. Commands are accepted on i_cmd_valid && o_cmd_ready.
  - Acceptance latches op/mode/addr/len/seed.
  - Acceptance clears o_err, o_err_count and o_first_err_addr, and sets o_busy.
  - i_cmd_valid while busy is ignored.
- States: IDLE, WRITE, TURN, READ, DRAIN, DONE.
  - Acceptance -> WRITE (WRITE, VERIFY) or READ (READ).
  - len=0 -> DONE directly, no beats.
- Beat i (0..len-1):
  - o_address = addr+i mod 2^ADDR_WIDTH (wrap-around).
  - Data for INCR = seed+i mod 2^DATA_WIDTH; CONST = seed; ADDR_XOR = seed XOR zero-extended/truncated beat address.
- Beats are registered and gap-free: the first beat is driven in the cycle after acceptance; o_wr_en or o_rd_en stays high for exactly len consecutive cycles.
  - o_wr_en and o_rd_en are never high together.
- Output values between and after beats:
  - o_wr_data holds its last value when o_wr_en=0.
  - o_address holds its last value after a burst.
- WRITE exits after the last beat:
  - To TURN for VERIFY: one cycle, both enables low.
  - To DONE for a plain WRITE.
- READ beat driven in cycle t: i_rd_data is sampled at the end of cycle t+RD_LATENCY. o_rd_valid=1 and o_rd_data=sampled value in cycle t+RD_LATENCY+1.
  - A RD_LATENCY-deep pipeline carries valid, expected data and address alongside.
- After the last read beat -> DRAIN until the pipeline is empty, then -> DONE.
  - DONE lasts one cycle, coincident with the last o_rd_valid for READ/VERIFY.
- DONE: o_done=1 for one cycle, o_busy=0 from the following cycle, state IDLE.
- Compare (VERIFY only) on each captured beat: mismatch if sampled data != expected.
  - On mismatch: o_err=1 and o_err_count increments, saturating at 2^ERR_WIDTH-1.
  - o_first_err_addr is loaded only on the first mismatch of the command.
  - Error outputs update in the same cycle as the corresponding o_rd_valid.
  - Error outputs hold after DONE until the next acceptance.

Test Plan:
- Reset, WRITE addr 0x10 len 4 INCR seed 0xA0 -> o_wr_en high 4 consecutive cycles starting the cycle after acceptance, addr 10..13, data A0..A3; o_done one cycle. Then READ same -> o_rd_data A0,A1,A2,A3.
- WRITE addr 0xFE len 4 CONST seed 0x5A -> addresses FE,FF,00,01, all data 5A. READ back -> four 5A beats.
- VERIFY addr 0x20 len 4 ADDR_XOR seed 0xFF with clean memory -> data DF,DE,DD,DC; one TURN cycle between phases; o_err=0, o_err_count=0. Repeat with the memory model flipping bit 0 at 0x22 -> o_err=1, o_err_count=1, o_first_err_addr=0x22.
- RD_LATENCY=3 instance, READ len 3 -> o_rd_valid high 3 consecutive cycles starting 4 cycles after the first o_rd_en cycle; o_done on the third valid.
- len=0 command -> no enables, o_done pulse the cycle after acceptance. i_cmd_valid held during a busy burst -> ignored, no second burst.
- i_rst asserted during beat 3 of an 8-beat WRITE -> enables 0 next cycle, no o_done, o_cmd_ready=1 the first cycle after i_rst deasserts; memory contains only beats 0..2.
